// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-side memory bus: owner and arbiter state
// encodings plus the cache line length.
package mem_arbiter_pkg;

    localparam int LINE_WORDS = 4;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_DATA
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the side that did not win last time
// gets the bus.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic   clk_core,
    input  logic   reset,
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    input  logic   i_update,
    input  owner_e i_update_owner,
    output logic   o_grant_valid,
    output owner_e o_grant_owner
);

    owner_e r_last_grant;

    // History only moves when a command is accepted, not when it is picked.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_last_grant <= OWN_IC;
        end else if (i_update) begin
            r_last_grant <= i_update_owner;
        end
    end

    always_comb begin
        o_grant_valid = i_req_ic | i_req_dc;
        o_grant_owner = OWN_IC;
        if (i_req_ic && i_req_dc) begin
            o_grant_owner = (r_last_grant == OWN_IC) ? OWN_DC : OWN_IC;
        end else if (i_req_dc) begin
            o_grant_owner = OWN_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between icache refills and dcache
// refills/writebacks, one whole-line burst at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BEATS  = LINE_WORDS,
    parameter int BEAT_W = $clog2(BEATS)
)(
    input  logic        clk_core,
    input  logic        reset,
    input  logic        ic_req,
    input  logic [29:0] ic_addr,
    input  logic        ic_abort,
    output logic        ic_ack,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_done,
    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [29:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_wnext,
    output logic        dc_ack,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_done,
    output logic        bus_cmd_valid,
    input  logic        bus_cmd_ready,
    output logic        bus_cmd_we,
    output logic [29:0] bus_cmd_addr,
    output logic        bus_wvalid,
    output logic [31:0] bus_wdata,
    input  logic        bus_wready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    owner_e            r_owner;
    logic              r_we;
    logic [29:0]       r_addr;
    logic [BEAT_W-1:0] r_cnt;
    logic              r_kill;

    logic              w_ic_eligible;
    logic              w_grant_valid;
    owner_e            w_grant_owner;
    logic              w_cmd_fire;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_kill_now;
    logic              w_abort_ic;
    logic [29:0]       w_line_mask;

    assign w_line_mask   = ~30'(BEATS - 1);
    assign w_ic_eligible = ic_req & ~ic_abort;
    assign w_cmd_fire    = (r_state == ARB_CMD) & bus_cmd_ready;
    assign w_beat        = (r_state == ARB_DATA) & (r_we ? bus_wready : bus_rvalid);
    assign w_last_beat   = w_beat & (r_cnt == BEAT_W'(BEATS - 1));
    assign w_abort_ic    = ic_abort & (r_owner == OWN_IC);
    // An abort silences the beat arriving in the same cycle, not just later ones.
    assign w_kill_now    = r_kill | w_abort_ic;

    rr_arb2 u_rr_arb2 (
        .clk_core       (clk_core),
        .reset          (reset),
        .i_req_ic       (w_ic_eligible),
        .i_req_dc       (dc_req),
        .i_update       (w_cmd_fire),
        .i_update_owner (r_owner),
        .o_grant_valid  (w_grant_valid),
        .o_grant_owner  (w_grant_owner)
    );

    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ARB_IDLE: if (w_grant_valid) w_state_next = ARB_CMD;
            ARB_CMD:  if (bus_cmd_ready) w_state_next = ARB_DATA;
            ARB_DATA: if (w_last_beat)   w_state_next = ARB_IDLE;
            default:  w_state_next = ARB_IDLE;
        endcase
    end

    // Burst context is captured at grant time so the caches may change their
    // request fields once acked.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_owner <= OWN_IC;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        r_we    <= (w_grant_owner == OWN_DC) & dc_we;
                        r_addr  <= ((w_grant_owner == OWN_DC) ? dc_addr : ic_addr) & w_line_mask;
                    end
                end
                ARB_CMD: begin
                    if (w_abort_ic) r_kill <= 1'b1;
                    if (bus_cmd_ready) r_cnt <= '0;
                end
                ARB_DATA: begin
                    if (w_abort_ic) r_kill <= 1'b1;
                    if (w_beat) r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
                    if (w_last_beat) r_kill <= 1'b0;
                end
                default: r_kill <= 1'b0;
            endcase
        end
    end

    // Reset gates every output so a burst cut short by reset never shows a
    // beat or done pulse.
    always_comb begin
        ic_ack        = 1'b0;
        ic_rvalid     = 1'b0;
        ic_rdata      = '0;
        ic_done       = 1'b0;
        dc_wnext      = 1'b0;
        dc_ack        = 1'b0;
        dc_rvalid     = 1'b0;
        dc_rdata      = '0;
        dc_done       = 1'b0;
        bus_cmd_valid = 1'b0;
        bus_cmd_we    = 1'b0;
        bus_cmd_addr  = '0;
        bus_wvalid    = 1'b0;
        bus_wdata     = '0;
        if (!reset) begin
            unique case (r_state)
                ARB_CMD: begin
                    bus_cmd_valid = 1'b1;
                    bus_cmd_we    = r_we;
                    bus_cmd_addr  = r_addr;
                    ic_ack        = bus_cmd_ready & (r_owner == OWN_IC);
                    dc_ack        = bus_cmd_ready & (r_owner == OWN_DC);
                end
                ARB_DATA: begin
                    if (r_we) begin
                        bus_wvalid = 1'b1;
                        bus_wdata  = dc_wdata;
                        dc_wnext   = bus_wready;
                        dc_done    = w_last_beat;
                    end else if (r_owner == OWN_IC) begin
                        if (!w_kill_now) begin
                            ic_rvalid = bus_rvalid;
                            ic_rdata  = bus_rvalid ? bus_rdata : '0;
                            ic_done   = w_last_beat;
                        end
                    end else begin
                        dc_rvalid = bus_rvalid;
                        dc_rdata  = bus_rvalid ? bus_rdata : '0;
                        dc_done   = w_last_beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts the
// command order and beat data, a separate monitor checks what the DUT presents.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int BEATS   = LINE_WORDS;
    localparam int TIMEOUT = 400;

    logic        clk_core = 1'b0;
    logic        reset = 1'b1;
    logic        ic_req = 1'b0;
    logic [29:0] ic_addr = '0;
    logic        ic_abort = 1'b0;
    logic        ic_ack, ic_rvalid, ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [29:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic        dc_wnext, dc_ack, dc_rvalid, dc_done;
    logic [31:0] dc_rdata;
    logic        bus_cmd_valid, bus_cmd_we, bus_wvalid;
    logic [29:0] bus_cmd_addr;
    logic [31:0] bus_wdata;
    logic        bus_cmd_ready = 1'b0;
    logic        bus_wready = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk_core = ~clk_core;

    mem_arbiter #(.BEATS(BEATS)) dut (
        .clk_core(clk_core), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_abort(ic_abort), .ic_ack(ic_ack),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wnext(dc_wnext), .dc_ack(dc_ack), .dc_rvalid(dc_rvalid),
        .dc_rdata(dc_rdata), .dc_done(dc_done),
        .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
        .bus_cmd_we(bus_cmd_we), .bus_cmd_addr(bus_cmd_addr),
        .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata), .bus_wready(bus_wready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        we;
        logic        isDc;
        logic [29:0] addr;
    } cmd_t;

    cmd_t        expCmd[$];
    logic [31:0] expIc[$];
    logic [31:0] expDcR[$];
    logic [31:0] expW[$];

    int tests = 0, failed = 0, cycle = 0;
    int expIcDone = 0, expDcDone = 0, icDoneCnt = 0, dcDoneCnt = 0;
    int icAckCnt = 0, dcAckCnt = 0, burstsDone = 0, timeouts = 0;
    bit benchDone = 0, expectNoCmd = 0;
    owner_e lastGrant = OWN_IC;

    // Bus-side and cache-side agent state, advanced by the monitor.
    bit          busActive = 0, busWe = 0, busIsDc = 0;
    logic [29:0] busAddr = '0;
    int          busCnt = 0, icBeatCnt = 0, dcBeatCnt = 0, wIdx = 0;
    logic [29:0] dcLine = '0;

    function automatic logic [29:0] lineOf(input logic [29:0] a);
        return a - (a % 30'(BEATS));
    endfunction

    function automatic logic [31:0] rdWord(input logic [29:0] line, input int i);
        return {2'b10, line + 30'(i)} ^ 32'h00C3_5A00;
    endfunction

    function automatic logic [31:0] wrWord(input logic [29:0] line, input int i);
        return {2'b01, line + 30'(i)} ^ 32'h0F0F_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Bus slave and dcache write-data source, driven just after each edge.
    always @(posedge clk_core) begin
        #1;
        bus_cmd_ready = ($urandom_range(0, 2) != 0);
        bus_rvalid    = ($urandom_range(0, 3) != 0);
        bus_rdata     = (busActive && !busWe) ? rdWord(busAddr, busCnt) : $urandom;
        bus_wready    = ($urandom_range(0, 2) != 0);
        dc_wdata      = wrWord(dcLine, wIdx);
    end

    logic        anyOut, fire, wbeat, cmdPending = 0, postReset = 0;
    logic [29:0] pendAddr = '0;
    logic [31:0] e;
    cmd_t        c;

    always @(negedge clk_core) begin
        cycle++;
        anyOut = ic_ack | ic_rvalid | (|ic_rdata) | ic_done | dc_wnext | dc_ack |
                 dc_rvalid | (|dc_rdata) | dc_done | bus_cmd_valid | bus_cmd_we |
                 (|bus_cmd_addr) | bus_wvalid | (|bus_wdata);
        if (reset) begin
            checkOutput("reset_outputs_zero", 64'(anyOut), 64'd0);
            expCmd.delete(); expIc.delete(); expDcR.delete(); expW.delete();
            busActive = 0; busCnt = 0; icBeatCnt = 0; dcBeatCnt = 0; wIdx = 0;
            cmdPending = 0; postReset = 1;
        end else begin
            if (postReset) checkOutput("post_reset_idle_outputs", 64'(anyOut), 64'd0);
            postReset = 0;
            if (expectNoCmd) checkOutput("abort_blocks_ic_grant", 64'(bus_cmd_valid), 64'd0);
            if (cmdPending) begin
                checkOutput("cmd_valid_held", 64'(bus_cmd_valid), 64'd1);
                checkOutput("cmd_addr_stable", 64'(bus_cmd_addr), 64'(pendAddr));
            end
            fire = bus_cmd_valid & bus_cmd_ready;
            if ((ic_ack || dc_ack) && !fire)
                checkOutput("ack_without_handshake", 64'({ic_ack, dc_ack}), 64'd0);
            if (ic_ack) icAckCnt++;
            if (dc_ack) dcAckCnt++;

            if (ic_rvalid) begin
                if (expIc.size() == 0) checkOutput("ic_rvalid_unexpected", 64'd1, 64'd0);
                else begin
                    e = expIc.pop_front();
                    checkOutput("ic_rdata", 64'(ic_rdata), 64'(e));
                end
                if (ic_done) begin
                    checkOutput("ic_done_on_last_beat", 64'(icBeatCnt), 64'(BEATS - 1));
                    icDoneCnt++;
                end
                icBeatCnt++;
            end else if (ic_done) checkOutput("ic_done_without_beat", 64'd1, 64'd0);

            wbeat = bus_wvalid & bus_wready;
            if (bus_wvalid) checkOutput("wvalid_in_write_burst", 64'(busActive && busWe), 64'd1);
            if (bus_wvalid || dc_wnext) checkOutput("dc_wnext", 64'(dc_wnext), 64'(wbeat));
            if (wbeat) begin
                if (expW.size() == 0) checkOutput("write_beat_unexpected", 64'd1, 64'd0);
                else begin
                    e = expW.pop_front();
                    checkOutput("bus_wdata", 64'(bus_wdata), 64'(e));
                end
            end
            if (dc_rvalid) begin
                if (expDcR.size() == 0) checkOutput("dc_rvalid_unexpected", 64'd1, 64'd0);
                else begin
                    e = expDcR.pop_front();
                    checkOutput("dc_rdata", 64'(dc_rdata), 64'(e));
                end
            end
            if (dc_rvalid || wbeat) begin
                if (dc_done) begin
                    checkOutput("dc_done_on_last_beat", 64'(dcBeatCnt), 64'(BEATS - 1));
                    dcDoneCnt++;
                end
                dcBeatCnt++;
            end else if (dc_done) checkOutput("dc_done_without_beat", 64'd1, 64'd0);
            if (dc_wnext) wIdx++;

            if (busActive && (busWe ? wbeat : bus_rvalid)) begin
                busCnt++;
                if (busCnt == BEATS) begin
                    busActive = 0;
                    burstsDone++;
                end
            end
            if (fire) begin
                if (expCmd.size() == 0) begin
                    checkOutput("cmd_unexpected", 64'd1, 64'd0);
                    busIsDc = dc_ack;
                end else begin
                    c = expCmd.pop_front();
                    checkOutput("cmd_we", 64'(bus_cmd_we), 64'(c.we));
                    checkOutput("cmd_addr", 64'(bus_cmd_addr), 64'(c.addr));
                    checkOutput("ack_owner", 64'({ic_ack, dc_ack}), c.isDc ? 64'd1 : 64'd2);
                    busIsDc = c.isDc;
                end
                busActive = 1; busWe = bus_cmd_we; busAddr = bus_cmd_addr; busCnt = 0;
                if (busIsDc) begin
                    dcBeatCnt = 0;
                    wIdx = 0;
                end else icBeatCnt = 0;
            end
            cmdPending = bus_cmd_valid & ~bus_cmd_ready;
            pendAddr   = bus_cmd_addr;
        end

        if (cycle > 50000) begin
            checkOutput("watchdog_expired", 64'd1, 64'd0);
            $display("[TB] %0d tests run, %0d failed", tests, failed);
            $finish;
        end
        if (benchDone) begin
            checkOutput("cmd_queue_drained", 64'(expCmd.size()), 64'd0);
            checkOutput("ic_data_drained", 64'(expIc.size()), 64'd0);
            checkOutput("dc_data_drained", 64'(expDcR.size() + expW.size()), 64'd0);
            checkOutput("ic_done_count", 64'(icDoneCnt), 64'(expIcDone));
            checkOutput("dc_done_count", 64'(dcDoneCnt), 64'(expDcDone));
            checkOutput("round_timeouts", 64'(timeouts), 64'd0);
            $display("[TB] %0d tests run, %0d failed", tests, failed);
            $finish;
        end
    end

    task automatic pushIc(input logic [29:0] a, input int abortAt);
        int n;
        n = (abortAt > 0) ? abortAt : BEATS;
        expCmd.push_back('{we: 1'b0, isDc: 1'b0, addr: lineOf(a)});
        for (int i = 0; i < n; i++) expIc.push_back(rdWord(lineOf(a), i));
        if (abortAt == 0) expIcDone++;
        lastGrant = OWN_IC;
    endtask

    task automatic pushDc(input logic we, input logic [29:0] a);
        expCmd.push_back('{we: we, isDc: 1'b1, addr: lineOf(a)});
        for (int i = 0; i < BEATS; i++) begin
            if (we) expW.push_back(wrWord(lineOf(a), i));
            else    expDcR.push_back(rdWord(lineOf(a), i));
        end
        expDcDone++;
        lastGrant = OWN_DC;
    endtask

    // Raise the requests of one round together while the arbiter is idle.
    task automatic issueRound(input bit doIc, input logic [29:0] icA, input bit doDc,
                              input bit dcWe, input logic [29:0] dcA, input int abortAt);
        bit icFirst;
        icFirst = (doIc && doDc) ? (lastGrant == OWN_DC) : doIc;
        if (icFirst) begin
            pushIc(icA, abortAt);
            if (doDc) pushDc(dcWe, dcA);
        end else begin
            if (doDc) pushDc(dcWe, dcA);
            if (doIc) pushIc(icA, abortAt);
        end
        if (doDc) begin
            dcLine = lineOf(dcA);
            dc_we = dcWe; dc_addr = dcA; dc_req = 1'b1;
        end
        if (doIc) begin
            ic_addr = icA; ic_req = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit doIc, input logic [29:0] icA, input bit doDc,
                                 input bit dcWe, input logic [29:0] dcA, input int abortAt,
                                 input bit noise);
        int target, icAcks0, dcAcks0;
        bit aborted;
        target  = burstsDone + int'(doIc) + int'(doDc);
        icAcks0 = icAckCnt;
        dcAcks0 = dcAckCnt;
        aborted = 0;
        issueRound(doIc, icA, doDc, dcWe, dcA, abortAt);
        for (int w = 0; w < TIMEOUT && burstsDone < target; w++) begin
            @(posedge clk_core); #1;
            if (icAckCnt != icAcks0) ic_req = 1'b0;
            if (dcAckCnt != dcAcks0) dc_req = 1'b0;
            ic_abort = 1'b0;
            if (abortAt > 0 && !aborted && busActive && !busIsDc && icBeatCnt == abortAt) begin
                ic_abort = 1'b1;
                aborted  = 1;
            end else if (noise && busActive && busIsDc && $urandom_range(0, 3) == 0) begin
                ic_abort = 1'b1;
            end
        end
        ic_abort = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
        if (burstsDone < target) timeouts++;
        repeat (2) @(posedge clk_core);
        #1;
    endtask

    task automatic resetMidBurst();
        int savedIc, savedDc, w;
        savedIc = expIcDone;
        savedDc = expDcDone;
        issueRound(1'b0, '0, 1'b1, 1'b0, 30'h0ABC_DE01, 0);
        for (w = 0; w < TIMEOUT && !(busActive && busCnt == 2); w++) begin
            @(posedge clk_core); #1;
        end
        if (w == TIMEOUT) timeouts++;
        reset = 1'b1; dc_req = 1'b0; ic_req = 1'b0;
        @(posedge clk_core); #1;
        reset = 1'b0;
        expIcDone = savedIc;
        expDcDone = savedDc;
        lastGrant = OWN_IC;
        repeat (2) @(posedge clk_core);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_core);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk_core);
        #1;
        $display("[TB] directed: icache refill, tie after reset, writeback, abort");
        applyStimulus(1'b1, 30'h0000_1237, 1'b0, 1'b0, '0, 0, 1'b0);
        applyStimulus(1'b1, 30'h0000_2000, 1'b1, 1'b0, 30'h0000_3003, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 30'h0001_0042, 0, 1'b0);
        applyStimulus(1'b1, 30'h0000_4444, 1'b1, 1'b0, 30'h0000_5555, 2, 1'b0);

        ic_addr = 30'h0000_0777; ic_req = 1'b1; ic_abort = 1'b1; expectNoCmd = 1'b1;
        repeat (3) @(posedge clk_core);
        #1 ic_abort = 1'b0; expectNoCmd = 1'b0;
        applyStimulus(1'b1, 30'h0000_0777, 1'b0, 1'b0, '0, 0, 1'b0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 16; r++) begin
            int mode;
            mode = $urandom_range(1, 3);
            applyStimulus(mode[0], 30'($urandom), mode[1], 1'($urandom),
                          30'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, BEATS - 1) : 0,
                          1'b1);
        end

        $display("[TB] reset mid-burst, then alternating ties");
        resetMidBurst();
        for (int r = 0; r < 3; r++)
            applyStimulus(1'b1, 30'(32'h100 * (r + 1) + 5), 1'b1, 1'(r),
                          30'(32'h200 * (r + 1) + 6), 0, 1'b0);
        benchDone = 1'b1;
    end

endmodule
